// File: rtl/mux8to1_sync.sv
// Eight-lane selector: a combinational output that follows the select directly,
// and a registered copy of the selected lane and its select code with a one-cycle valid strobe.
module mux8to1_sync #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*WIDTH-1:0] a,
  input  logic [2:0]         s,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   c_q,
  output logic [2:0]         s_q,
  output logic               out_valid
);

  logic [WIDTH-1:0] lanes [8];

  // Split the packed bus into lanes, with lane 0 taken from the LSBs.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lanes[k] = a[k*WIDTH +: WIDTH];
    end
  end

  // Every select code maps to a lane, so a known select never gives X.
  always_comb begin
    c = lanes[s];
  end

  // Capture register. Reset wins over in_valid.
  // The data and select hold when in_valid is low, but the valid flag drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q       <= '0;
      s_q       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      c_q       <= lanes[s];
      s_q       <= s;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8to1_sync.sv
// Bench for mux8to1_sync.
// Instance u1 is the 1-bit build and u4 is the 4-bit build.
// Each accepted capture is pushed to a queue, and the entry is popped and checked when out_valid shows.
`timescale 1ns/1ps
module tb_mux8to1_sync;

  typedef struct packed {
    logic [3:0] c;
    logic [2:0] s;
  } sb_t;

  logic        clk = 1'b0;

  logic        rst1 = 1'b0;
  logic [7:0]  a1 = '0;
  logic [2:0]  s1 = '0;
  logic        in_valid1 = 1'b0;
  logic        c1, c_q1, out_valid1;
  logic [2:0]  s_q1;

  logic        rst4 = 1'b0;
  logic [31:0] a4 = '0;
  logic [2:0]  s4 = '0;
  logic        in_valid4 = 1'b0;
  logic [3:0]  c4, c_q4;
  logic [2:0]  s_q4;
  logic        out_valid4;

  int n_checks = 0;
  int n_errors = 0;

  sb_t q1[$];
  sb_t q4[$];
  logic [3:0] hold_c1, hold_c4;
  logic [2:0] hold_s1, hold_s4;

  mux8to1_sync #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .a(a1), .s(s1), .in_valid(in_valid1),
    .c(c1), .c_q(c_q1), .s_q(s_q1), .out_valid(out_valid1)
  );

  mux8to1_sync #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .a(a4), .s(s4), .in_valid(in_valid4),
    .c(c4), .c_q(c_q4), .s_q(s_q4), .out_valid(out_valid4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one clock cycle on u1.
  // The combinational output is checked before the edge; the registered outputs are checked after it.
  task automatic cycle1(input logic r, input logic v, input logic [7:0] aa, input logic [2:0] ss,
                        input logic exp_c);
    sb_t e;
    rst1 = r; in_valid1 = v; a1 = aa; s1 = ss;
    if (!r && v) q1.push_back({3'b000, aa[ss], ss});
    #1;
    check_eq("c1_live", {31'd0, c1}, {31'd0, exp_c});
    @(posedge clk); #1;
    if (r) begin
      hold_c1 = '0; hold_s1 = '0;
    end
    check_eq("out_valid1", {31'd0, out_valid1}, {31'd0, (!r && v)});
    if (out_valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        check_eq("sb1_nonempty", 32'(q1.size()), 32'd1);
      end else begin
        e = q1.pop_front();
        hold_c1 = e.c; hold_s1 = e.s;
      end
    end
    check_eq("c_q1", {31'd0, c_q1}, {31'd0, hold_c1[0]});
    check_eq("s_q1", {29'd0, s_q1}, {29'd0, hold_s1});
  endtask

  // Runs one clock cycle on u4, with the same checking scheme as cycle1.
  task automatic cycle4(input logic r, input logic v, input logic [31:0] aa, input logic [2:0] ss,
                        input logic [3:0] exp_c);
    sb_t e;
    rst4 = r; in_valid4 = v; a4 = aa; s4 = ss;
    if (!r && v) q4.push_back({exp_c, ss});
    #1;
    check_eq("c4_live", {28'd0, c4}, {28'd0, exp_c});
    @(posedge clk); #1;
    if (r) begin
      hold_c4 = '0; hold_s4 = '0;
    end
    check_eq("out_valid4", {31'd0, out_valid4}, {31'd0, (!r && v)});
    if (out_valid4 === 1'b1) begin
      if (q4.size() == 0) begin
        check_eq("sb4_nonempty", 32'(q4.size()), 32'd1);
      end else begin
        e = q4.pop_front();
        hold_c4 = e.c; hold_s4 = e.s;
      end
    end
    check_eq("c_q4", {28'd0, c_q4}, {28'd0, hold_c4});
    check_eq("s_q4", {29'd0, s_q4}, {29'd0, hold_s4});
  endtask

  initial begin
    int pat_exp [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [10:0] sa;
    logic [7:0]  ra;
    logic [2:0]  rs;
    logic        rv, rr;

    hold_c1 = '0; hold_s1 = '0; hold_c4 = '0; hold_s4 = '0;

    // Exhaustive combinational sweep over {s, a}. The expected bit is taken by shifting, not by muxing.
    for (int i = 0; i < 2048; i++) begin
      sa = 11'(i);
      s1 = sa[10:8]; a1 = sa[7:0];
      #1;
      check_eq("comb_exh", {31'd0, c1}, 32'((a1 >> s1) & 8'h01));
    end

    // Fixed pattern.
    a1 = 8'b1010_0101;
    for (int k = 0; k < 8; k++) begin
      s1 = 3'(k);
      #1;
      check_eq("comb_pat", {31'd0, c1}, 32'(pat_exp[k]));
    end

    // Registered path on u1. Start just after an edge.
    @(posedge clk); #1;
    cycle1(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle1(1'b0, 1'b1, 8'h80, 3'd7, 1'b1);
    cycle1(1'b0, 1'b0, 8'h80, 3'd7, 1'b1);
    for (int k = 0; k < 5; k++) cycle1(1'b0, 1'b0, 8'h00, 3'd3, 1'b0);
    cycle1(1'b1, 1'b1, 8'hFF, 3'd5, 1'b1);
    cycle1(1'b0, 1'b1, 8'hFF, 3'd5, 1'b1);
    cycle1(1'b0, 1'b0, 8'hFF, 3'd5, 1'b1);

    // Random traffic: back-to-back captures, gaps, and occasional resets.
    for (int k = 0; k < 60; k++) begin
      ra = 8'($urandom); rs = 3'($urandom_range(0, 7));
      rv = 1'($urandom_range(0, 3) != 0);
      rr = 1'($urandom_range(0, 15) == 0);
      cycle1(rr, rv, ra, rs, ra[rs]);
    end
    cycle1(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    check_eq("sb1_drained", 32'(q1.size()), 32'd0);

    // Wide lanes on u4. In a = 32'h7654_3210, lane k holds the value k.
    cycle4(1'b1, 1'b0, 32'h7654_3210, 3'd0, 4'd0);
    for (int k = 0; k < 8; k++) cycle4(1'b0, 1'b1, 32'h7654_3210, 3'(k), 4'(k));
    cycle4(1'b0, 1'b0, 32'h7654_3210, 3'd2, 4'd2);
    cycle4(1'b1, 1'b1, 32'hFEDC_BA98, 3'd6, 4'hE);
    cycle4(1'b0, 1'b1, 32'hFEDC_BA98, 3'd6, 4'hE);
    cycle4(1'b0, 1'b0, 32'hFEDC_BA98, 3'd1, 4'h9);
    check_eq("sb4_drained", 32'(q4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux8to1_sync.md
Name: mux8to1_sync

Overview:
- Eight-input, one-output selector with a combinational (dataflow) path and a registered path.
- Sits in the datapath wherever one of eight lanes is chosen by a 3-bit select.
- The combinational output is a pure function of data and select. The registered output adds one cycle of latency and a valid flag for downstream pipelined logic.

Parameters:
- WIDTH, 1, bit width of each of the eight data lanes (1 = single-bit mux).

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- a  input  8*WIDTH  packed data lanes; lane k = a[k*WIDTH +: WIDTH], lane 0 in the LSBs.
- s  input  3  lane select, s[0] is the LSB; value k selects lane k.
- in_valid  input  1  capture strobe for the registered path.
- c  output  WIDTH  combinational selected lane.
- c_q  output  WIDTH  registered selected lane.
- s_q  output  3  select value captured with c_q.
- out_valid  output  1  high for one cycle after each accepted capture.

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high and is sampled only on the rising edge of clk.
- Combinational path:
  - c = lane s of a at all times. It does not depend on clk, rst or in_valid.
  - All 8 select codes are legal; there is no out-of-range case.
  - c must never be X when a and s are known.
  - Required truth table, WIDTH=1: s=000 -> a[0], 001 -> a[1], 010 -> a[2], 011 -> a[3], 100 -> a[4], 101 -> a[5], 110 -> a[6], 111 -> a[7].
- Registered path, evaluated at each rising edge of clk:
  - rst=1: c_q <= 0, s_q <= 0, out_valid <= 0. Reset has priority over in_valid.
  - rst=0 and in_valid=1: c_q <= lane s of a, s_q <= s, out_valid <= 1.
  - rst=0 and in_valid=0: c_q and s_q hold their values, out_valid <= 0.
- Latency: c_q/s_q reflect the inputs sampled at edge N and are valid from edge N until edge N+1. out_valid is asserted for that same interval.
- Back-to-back captures: in_valid high on consecutive cycles keeps out_valid high, and c_q updates every cycle. There is no backpressure.
- Reset mid-operation:
  - The registered outputs clear on the edge where rst=1, whatever the value of in_valid.
  - c keeps tracking its inputs during reset.
- Power-up: registered outputs are undefined until the first reset edge. Benches must apply rst before checking c_q/s_q/out_valid.
- Widths: no arithmetic. Each lane is passed through unchanged, bit for bit, for any WIDTH >= 1.

Test Plan:
- Exhaustive combinational check, WIDTH=1: step an 11-bit counter {s,a} from 0 to 2047 with one value per time unit. After each step, c must equal a[s], for all 2048 combinations.
- Fixed pattern, WIDTH=1: a=8'b1010_0101, s swept 0..7 -> c = 1,0,1,0,0,1,0,1.
- Registered capture, WIDTH=1:
  - Apply rst=1 for one edge -> c_q=0, s_q=0, out_valid=0.
  - Then a=8'h80, s=7, in_valid=1 for one edge -> c_q=1, s_q=7, out_valid=1.
  - Next edge with in_valid=0 -> out_valid=0, c_q stays 1.
- Hold with changing inputs: after capturing c_q=1, drive in_valid=0, a=8'h00 and s=3 for 5 cycles. c_q stays 1 and s_q stays 7, while c=0.
- Reset priority: rst=1 and in_valid=1 on the same edge, with a=8'hFF -> c_q=0, out_valid=0. On the following edge with rst=0 and in_valid=1 -> c_q=1, out_valid=1.
- Wide lanes, WIDTH=4: a=32'h7654_3210, s swept 0..7 -> c = 0,1,2,3,4,5,6,7. With in_valid=1 on every cycle, c_q follows the same sequence one cycle later and out_valid stays high continuously.
